// File: rtl/xcorr_mac_scheduler.sv
// Sample-rate scheduler: strobe generation, one shared multiplier for a*b, a*a and b*b,
// and block accumulation with a valid/ready result port. Define XCORR_EXT_STB_EN for an external strobe.
module xcorr_mac_scheduler #(
    parameter int DW      = 22,
    parameter int CLK_DIV = 1000,
    parameter int LOG2_N  = 8,
    parameter int MUL_LAT = 3,
    parameter int ACC_W   = 2*DW + LOG2_N
) (
    input  logic              clk,
    input  logic              reset,
`ifdef XCORR_EXT_STB_EN
    input  logic              ext_stb,
`endif
    input  logic [DW-1:0]     sig_a,
    input  logic [DW-1:0]     sig_b,
    output logic              sample_stb,
    output logic [DW-1:0]     mul_a,
    output logic [DW-1:0]     mul_b,
    output logic              mul_vld,
    input  logic [2*DW-1:0]   mul_p,
    output logic [ACC_W-1:0]  acc_ab,
    output logic [ACC_W-1:0]  acc_aa,
    output logic [ACC_W-1:0]  acc_bb,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              overrun,
    output logic              missed
);

    typedef enum logic [2:0] {
        IDLE,
        ISS_AB,
        ISS_AA,
        ISS_BB,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_AB   = 2'd1,
        TAG_AA   = 2'd2,
        TAG_BB   = 2'd3
    } tag_t;

    localparam int DRN_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(MUL_LAT);

    state_t                  state_q, state_d;
    logic [DRN_W-1:0]        drainCnt_q, drainCnt_d;
    logic [DW-1:0]           sampleA_q, sampleB_q;
    logic [LOG2_N-1:0]       sampleCnt_q, sampleCnt_d;
    tag_t                    issueTag;
    tag_t                    retireTag;
    tag_t [MUL_LAT-1:0]      tagPipe_q, tagPipe_d;
    logic [ACC_W-1:0]        accAb_q, accAb_d;
    logic [ACC_W-1:0]        accAa_q, accAa_d;
    logic [ACC_W-1:0]        accBb_q, accBb_d;
    logic [ACC_W-1:0]        outAb_q, outAb_d;
    logic [ACC_W-1:0]        outAa_q, outAa_d;
    logic [ACC_W-1:0]        outBb_q, outBb_d;
    logic                    resValid_q, resValid_d;
    logic                    overrun_q, overrun_d;
    logic                    missed_q, missed_d;
    logic                    sampleDone;
    logic                    blockDone;
    logic [ACC_W-1:0]        prodExt;

`ifdef XCORR_EXT_STB_EN
    logic stb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= ext_stb;
        end
    end

    assign sample_stb = stb_q;
`else
    localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;

    always_comb begin
        divCnt_d = divCnt_q + DIV_W'(1);
        if (divCnt_q == DIV_LAST) begin
            divCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

    assign sample_stb = (divCnt_q == DIV_LAST);
`endif

    // Issue sequencing: one operand pair per cycle, then hold off until the last product lands.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        mul_vld    = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        issueTag   = TAG_NONE;
        sampleDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_stb) begin
                    state_d = ISS_AB;
                end
            end
            ISS_AB: begin
                mul_vld  = 1'b1;
                mul_a    = sampleA_q;
                mul_b    = sampleB_q;
                issueTag = TAG_AB;
                state_d  = ISS_AA;
            end
            ISS_AA: begin
                mul_vld  = 1'b1;
                mul_a    = sampleA_q;
                mul_b    = sampleA_q;
                issueTag = TAG_AA;
                state_d  = ISS_BB;
            end
            ISS_BB: begin
                mul_vld    = 1'b1;
                mul_a      = sampleB_q;
                mul_b      = sampleB_q;
                issueTag   = TAG_BB;
                drainCnt_d = '0;
                state_d    = DRAIN;
            end
            DRAIN: begin
                if (drainCnt_q == DRAIN_LAST) begin
                    sampleDone = 1'b1;
                    state_d    = IDLE;
                end else begin
                    drainCnt_d = drainCnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sampleA_q <= '0;
            sampleB_q <= '0;
        end else if (state_q == IDLE && sample_stb) begin
            sampleA_q <= sig_a;
            sampleB_q <= sig_b;
        end
    end

    // The tag travels alongside the multiplier pipeline so each product finds its accumulator.
    always_comb begin
        tagPipe_d[0] = issueTag;
        for (int i = 1; i < MUL_LAT; i++) begin
            tagPipe_d[i] = tagPipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tagPipe_q <= '{default: TAG_NONE};
        end else begin
            tagPipe_q <= tagPipe_d;
        end
    end

    assign retireTag = tagPipe_q[MUL_LAT-1];
    assign prodExt   = {{(ACC_W - 2*DW){mul_p[2*DW-1]}}, mul_p};

    always_comb begin
        sampleCnt_d = sampleCnt_q;
        if (sampleDone) begin
            sampleCnt_d = sampleCnt_q + LOG2_N'(1);
        end
    end

    assign blockDone = sampleDone && (&sampleCnt_q);

    always_comb begin
        accAb_d = accAb_q;
        accAa_d = accAa_q;
        accBb_d = accBb_q;
        case (retireTag)
            TAG_AB:  accAb_d = accAb_q + prodExt;
            TAG_AA:  accAa_d = accAa_q + prodExt;
            TAG_BB:  accBb_d = accBb_q + prodExt;
            default: ;
        endcase
        if (blockDone) begin
            accAb_d = '0;
            accAa_d = '0;
            accBb_d = '0;
        end
    end

    // A finished block always wins the output registers; overrun only when the old one was never taken.
    always_comb begin
        outAb_d    = outAb_q;
        outAa_d    = outAa_q;
        outBb_d    = outBb_q;
        resValid_d = resValid_q;
        overrun_d  = overrun_q;
        missed_d   = missed_q;
        if (blockDone) begin
            outAb_d    = accAb_q;
            outAa_d    = accAa_q;
            outBb_d    = accBb_q;
            resValid_d = 1'b1;
            if (resValid_q && !res_ready) begin
                overrun_d = 1'b1;
            end
        end else if (resValid_q && res_ready) begin
            resValid_d = 1'b0;
        end
        if (sample_stb && state_q != IDLE) begin
            missed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sampleCnt_q <= '0;
            accAb_q     <= '0;
            accAa_q     <= '0;
            accBb_q     <= '0;
            outAb_q     <= '0;
            outAa_q     <= '0;
            outBb_q     <= '0;
            resValid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            sampleCnt_q <= sampleCnt_d;
            accAb_q     <= accAb_d;
            accAa_q     <= accAa_d;
            accBb_q     <= accBb_d;
            outAb_q     <= outAb_d;
            outAa_q     <= outAa_d;
            outBb_q     <= outBb_d;
            resValid_q  <= resValid_d;
            overrun_q   <= overrun_d;
            missed_q    <= missed_d;
        end
    end

    assign acc_ab    = outAb_q;
    assign acc_aa    = outAa_q;
    assign acc_bb    = outBb_q;
    assign res_valid = resValid_q;
    assign overrun   = overrun_q;
    assign missed    = missed_q;
    assign busy      = (state_q != IDLE);

endmodule
